// File: rtl/rr_arb_pkg.sv
// Shared types and the round-robin search helper for rr_pipe_arbiter.
// Sized for the largest supported requester count; callers zero-extend and truncate.
package rr_arb_pkg;

  typedef enum logic {IDLE, LOCKED} arb_state_e;

  localparam int MAX_REQ  = 16;
  localparam int MAX_ID_W = 4;

  // First set bit of req[0 +: n], scanning from ptr upward and wrapping at n.
  // Returns 0 when nothing is requesting; callers qualify with |req.
  function automatic logic [MAX_ID_W-1:0] rr_pick(
    input logic [MAX_REQ-1:0]  req,
    input logic [MAX_ID_W-1:0] ptr,
    input int                  n
  );
    logic [MAX_ID_W-1:0] pick;
    logic [MAX_ID_W:0]   idx;
    logic                found;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = {1'b0, ptr} + (MAX_ID_W + 1)'(k);
      if (idx >= (MAX_ID_W + 1)'(n)) begin
        idx = idx - (MAX_ID_W + 1)'(n);
      end
      if (!found && (k < n) && req[idx[MAX_ID_W-1:0]]) begin
        pick  = idx[MAX_ID_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/single_stage_pipe.sv
// One-entry registered valid/ready stage; accepts a new beat in the same cycle
// the held one leaves, so it sustains one beat per cycle.
module single_stage_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rr_pipe_arbiter.sv
// Packet-aware round-robin arbiter feeding one registered output stage.
// A winner keeps the grant until its last beat is accepted; beats carry their source index.
module rr_pipe_arbiter
  import rr_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int WIDTH = 32,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       in_valid,
  input  logic [N_REQ-1:0]       in_last,
  input  logic [N_REQ*WIDTH-1:0] in_data,
  output logic [N_REQ-1:0]       in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [ID_W-1:0]        out_id,
  output logic                   out_last,
  input  logic                   out_ready
);

  localparam int PW = WIDTH + ID_W + 1;

  arb_state_e      state, state_next;
  logic [ID_W-1:0] rr_ptr, rr_ptr_next;
  logic [ID_W-1:0] lock_id, lock_id_next;
  logic [ID_W-1:0] rr_gnt, gnt;
  logic            stage_ready;
  logic            any_req;
  logic            accept;
  logic            sel_last;
  logic [WIDTH-1:0] sel_data;
  logic [PW-1:0]   stage_in, stage_out;

  assign rr_gnt = ID_W'(rr_pick(MAX_REQ'(in_valid), MAX_ID_W'(rr_ptr), N_REQ));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      lock_id <= '0;
    end else begin
      state   <= state_next;
      rr_ptr  <= rr_ptr_next;
      lock_id <= lock_id_next;
    end
  end

  // While locked only the owner may be served; a gap from it stalls everyone.
  // The rst_n term keeps in_ready low while reset is held.
  always_comb begin
    state_next   = state;
    rr_ptr_next  = rr_ptr;
    lock_id_next = lock_id;
    in_ready     = '0;
    gnt          = (state == LOCKED) ? lock_id : rr_gnt;
    any_req      = (state == LOCKED) ? in_valid[lock_id] : |in_valid;
    accept       = rst_n && any_req && stage_ready;
    sel_last     = in_last[gnt];
    sel_data     = in_data[int'(gnt)*WIDTH +: WIDTH];

    if (accept) begin
      in_ready[gnt] = 1'b1;
      rr_ptr_next   = (gnt == ID_W'(N_REQ - 1)) ? '0 : gnt + ID_W'(1);
      case (state)
        IDLE: begin
          if (!sel_last) begin
            state_next   = LOCKED;
            lock_id_next = gnt;
          end
        end
        LOCKED: begin
          if (sel_last) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign stage_in = {sel_last, gnt, sel_data};

  single_stage_pipe #(
    .WIDTH(PW)
  ) u_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (accept),
    .in_ready (stage_ready),
    .in_data  (stage_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (stage_out)
  );

  assign out_last = stage_out[PW-1];
  assign out_id   = stage_out[WIDTH +: ID_W];
  assign out_data = stage_out[WIDTH-1:0];

  a_in_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(in_ready));

  a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> $stable({out_valid, out_last, out_id, out_data}));

  a_lock_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    (state == LOCKED) |-> ((in_ready & ~(N_REQ'(1) << lock_id)) == '0));

endmodule

// File: tb/tb_rr_pipe_arbiter.sv
// Directed scenarios plus a long random run for rr_pipe_arbiter, checked against
// a cycle-level reference model whose predicted output beats queue up in exp_q.
module tb_rr_pipe_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 32;
  localparam int ID_W  = 2;

  typedef struct packed {
    logic            last;
    logic [ID_W-1:0] id;
    logic [WIDTH-1:0] data;
  } beat_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [N_REQ-1:0]       in_valid = '0;
  logic [N_REQ-1:0]       in_last = '0;
  logic [N_REQ*WIDTH-1:0] in_data = '0;
  logic [N_REQ-1:0]       in_ready;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic [ID_W-1:0]        out_id;
  logic                   out_last;
  logic                   out_ready = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  beat_t            exp_q[$];
  logic             m_locked = 1'b0;
  int               m_ptr = 0;
  int               m_lock = 0;
  logic [N_REQ-1:0] last_accept = '0;
  int               pushed_cnt = 0;
  int               popped_cnt = 0;

  always #5 clk = ~clk;

  rr_pipe_arbiter #(
    .N_REQ(N_REQ),
    .WIDTH(WIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_id   (out_id),
    .out_last (out_last),
    .out_ready(out_ready)
  );

  function automatic int model_gnt();
    if (m_locked) return m_lock;
    for (int k = 0; k < N_REQ; k++) begin
      int i;
      i = (m_ptr + k) % N_REQ;
      if (in_valid[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N_REQ-1:0] model_ready();
    logic [N_REQ-1:0] r;
    int g;
    r = '0;
    g = model_gnt();
    if (g >= 0 && in_valid[g] && (exp_q.size() == 0 || out_ready)) r[g] = 1'b1;
    return r;
  endfunction

  // Advance one clock: model decides acceptance from the inputs held before the edge.
  task automatic tick();
    logic [N_REQ-1:0] r;
    int g;
    beat_t b;
    logic pop_now;
    r = model_ready();
    g = model_gnt();
    b = '0;
    if (r != '0) begin
      b.last = in_last[g];
      b.id   = ID_W'(g);
      b.data = in_data[g*WIDTH +: WIDTH];
    end
    pop_now = (exp_q.size() != 0) && out_ready;
    @(posedge clk);
    if (pop_now) void'(exp_q.pop_front());
    if (r != '0) begin
      exp_q.push_back(b);
      pushed_cnt++;
      if (!m_locked && !b.last) begin
        m_locked = 1'b1;
        m_lock   = g;
      end else if (m_locked && b.last) begin
        m_locked = 1'b0;
      end
      m_ptr = (g + 1) % N_REQ;
    end
    last_accept = r;
    @(negedge clk);
  endtask

  task automatic set_beat(input int i, input logic v, input logic l, input logic [WIDTH-1:0] d);
    in_valid[i] = v;
    in_last[i]  = l;
    in_data[i*WIDTH +: WIDTH] = d;
  endtask

  task automatic clear_model();
    exp_q.delete();
    m_locked    = 1'b0;
    m_ptr       = 0;
    m_lock      = 0;
    last_accept = '0;
    pushed_cnt  = 0;
    popped_cnt  = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = '1;
    in_last   = '1;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: valid=%b last=%b expected 0 0", out_valid, out_last);
    end
    tests_run++;
    if (out_data !== '0 || out_id !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: data=%h id=%0d expected 0 0", out_data, out_id);
    end
    tests_run++;
    if (in_ready !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_ready: got %b expected 0000", in_ready);
    end
  endtask

  task automatic test_round_robin();
    logic [N_REQ-1:0] exp_rdy;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N_REQ; i++) set_beat(i, 1'b1, 1'b1, WIDTH'(32'h1000 + i));
    for (int c = 0; c < 5; c++) begin
      #1;
      exp_rdy = N_REQ'(1) << (c % N_REQ);
      tests_run++;
      if (in_ready !== exp_rdy) begin
        tests_failed++;
        $display("[TB] FAIL rr_in_ready[%0d]: got %b expected %b", c, in_ready, exp_rdy);
      end
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_id !== ID_W'(c % N_REQ) || out_data !== WIDTH'(32'h1000 + c % N_REQ)) begin
        tests_failed++;
        $display("[TB] FAIL rr_out[%0d]: valid=%b id=%0d data=%h expected 1 %0d %h",
                 c, out_valid, out_id, out_data, c % N_REQ, 32'h1000 + c % N_REQ);
      end
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_packet_lock();
    do_reset();
    out_ready = 1'b1;
    set_beat(2, 1'b1, 1'b1, 32'h2000_0000);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        set_beat(0, 1'b0, 1'b0, '0);
        #1;
        tests_run++;
        if (in_ready !== 4'b0000) begin
          tests_failed++;
          $display("[TB] FAIL lock_gap_ready: got %b expected 0000", in_ready);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL lock_gap_valid: got %b expected 0", out_valid);
        end
      end
      set_beat(0, 1'b1, k == 2, WIDTH'(32'h0100_0000 + k));
      #1;
      tests_run++;
      if (in_ready !== 4'b0001) begin
        tests_failed++;
        $display("[TB] FAIL lock_in_ready[%0d]: got %b expected 0001", k, in_ready);
      end
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_id !== 2'd0 || out_last !== (k == 2) ||
          out_data !== WIDTH'(32'h0100_0000 + k)) begin
        tests_failed++;
        $display("[TB] FAIL lock_out[%0d]: valid=%b id=%0d last=%b data=%h expected 1 0 %b %h",
                 k, out_valid, out_id, out_last, out_data, k == 2, 32'h0100_0000 + k);
      end
    end
    set_beat(0, 1'b0, 1'b0, '0);
    #1;
    tests_run++;
    if (in_ready !== 4'b0100) begin
      tests_failed++;
      $display("[TB] FAIL lock_release_ready: got %b expected 0100", in_ready);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_id !== 2'd2 || out_data !== 32'h2000_0000) begin
      tests_failed++;
      $display("[TB] FAIL lock_next_pkt: valid=%b id=%0d data=%h expected 1 2 20000000",
               out_valid, out_id, out_data);
    end
    set_beat(2, 1'b0, 1'b0, '0);
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    set_beat(1, 1'b1, 1'b1, 32'hA5A5_0001);
    #1;
    tests_run++;
    if (in_ready !== 4'b0010) begin
      tests_failed++;
      $display("[TB] FAIL stall_first_ready: got %b expected 0010", in_ready);
    end
    tick();
    set_beat(1, 1'b1, 1'b1, 32'hA5A5_0002);
    for (int c = 0; c < 5; c++) begin
      #1;
      tests_run++;
      if (in_ready !== 4'b0000) begin
        tests_failed++;
        $display("[TB] FAIL stall_in_ready[%0d]: got %b expected 0000", c, in_ready);
      end
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0001 || out_id !== 2'd1 || out_last !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL stall_hold[%0d]: valid=%b data=%h id=%0d last=%b expected 1 a5a50001 1 1",
                 c, out_valid, out_data, out_id, out_last);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 4'b0010) begin
      tests_failed++;
      $display("[TB] FAIL stall_release_ready: got %b expected 0010", in_ready);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0002) begin
      tests_failed++;
      $display("[TB] FAIL stall_follow: valid=%b data=%h expected 1 a5a50002", out_valid, out_data);
    end
    set_beat(1, 1'b0, 1'b0, '0);
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stall_drain: valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_single_requester();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_beat(3, 1'b1, 1'b1, WIDTH'(32'h0300_0000 + k));
      #1;
      tests_run++;
      if (in_ready !== 4'b1000) begin
        tests_failed++;
        $display("[TB] FAIL single_ready[%0d]: got %b expected 1000", k, in_ready);
      end
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_id !== 2'd3 || out_data !== WIDTH'(32'h0300_0000 + k)) begin
        tests_failed++;
        $display("[TB] FAIL single_out[%0d]: valid=%b id=%0d data=%h expected 1 3 %h",
                 k, out_valid, out_id, out_data, 32'h0300_0000 + k);
      end
    end
    set_beat(0, 1'b1, 1'b1, 32'h0000_00A0);
    set_beat(1, 1'b1, 1'b1, 32'h0000_00A1);
    set_beat(3, 1'b1, 1'b1, 32'h0000_00A3);
    #1;
    tests_run++;
    if (in_ready !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL wrap_ready: got %b expected 0001", in_ready);
    end
    tick();
    tests_run++;
    if (out_id !== 2'd0 || out_data !== 32'h0000_00A0) begin
      tests_failed++;
      $display("[TB] FAIL wrap_out: id=%0d data=%h expected 0 000000a0", out_id, out_data);
    end
    in_valid = '0;
    tick();
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    out_ready = 1'b1;
    set_beat(1, 1'b1, 1'b0, 32'h1111_0000);
    tick();
    set_beat(1, 1'b1, 1'b0, 32'h1111_0001);
    tick();
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL midreset_clear: valid=%b in_ready=%b expected 0 0000", out_valid, in_ready);
    end
    in_valid = '0;
    in_last  = '0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    set_beat(0, 1'b1, 1'b1, 32'h5555_0000);
    set_beat(2, 1'b1, 1'b1, 32'h5555_0002);
    #1;
    tests_run++;
    if (in_ready !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL midreset_grant: got %b expected 0001", in_ready);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== 32'h5555_0000) begin
      tests_failed++;
      $display("[TB] FAIL midreset_out: valid=%b id=%0d data=%h expected 1 0 55550000",
               out_valid, out_id, out_data);
    end
    in_valid = '0;
    repeat (2) tick();
  endtask

  task automatic test_random();
    int   seq_in[N_REQ];
    int   seq_out[N_REQ];
    logic prev_open;
    logic [ID_W-1:0] prev_id;
    beat_t got;
    do_reset();
    for (int i = 0; i < N_REQ; i++) begin
      seq_in[i]  = 0;
      seq_out[i] = 0;
    end
    prev_open = 1'b0;
    prev_id   = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      out_ready = ($urandom_range(3) != 0);
      for (int i = 0; i < N_REQ; i++) begin
        if (last_accept[i] || !in_valid[i]) begin
          set_beat(i, $urandom_range(1) == 1, $urandom_range(2) == 0,
                   {8'(i), 8'h5A, 16'(seq_in[i])});
        end
      end
      #1;
      tests_run++;
      if (in_ready !== model_ready()) begin
        tests_failed++;
        $display("[TB] FAIL rand_in_ready @%0d: got %b expected %b", cyc, in_ready, model_ready());
      end
      tests_run++;
      if (out_valid !== (exp_q.size() != 0)) begin
        tests_failed++;
        $display("[TB] FAIL rand_out_valid @%0d: got %b expected %b", cyc, out_valid, exp_q.size() != 0);
      end
      if (out_valid === 1'b1 && exp_q.size() != 0) begin
        got = {out_last, out_id, out_data};
        tests_run++;
        if (got !== exp_q[0]) begin
          tests_failed++;
          $display("[TB] FAIL rand_beat @%0d: got %h expected %h", cyc, got, exp_q[0]);
        end
        if (out_ready) begin
          popped_cnt++;
          tests_run++;
          if (prev_open && out_id !== prev_id) begin
            tests_failed++;
            $display("[TB] FAIL rand_interleave @%0d: id=%0d expected %0d", cyc, out_id, prev_id);
          end
          tests_run++;
          if (out_data[15:0] !== 16'(seq_out[out_id])) begin
            tests_failed++;
            $display("[TB] FAIL rand_order @%0d: src=%0d seq=%0d expected %0d",
                     cyc, out_id, out_data[15:0], seq_out[out_id]);
          end
          seq_out[out_id]++;
          prev_open = !out_last;
          prev_id   = out_id;
        end
      end
      tick();
      for (int i = 0; i < N_REQ; i++) begin
        if (last_accept[i]) seq_in[i]++;
      end
    end
    in_valid  = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (out_valid === 1'b1) popped_cnt++;
      tick();
    end
    tests_run++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL rand_drain: valid=%b queued=%0d expected 0 0", out_valid, exp_q.size());
    end
    tests_run++;
    if (popped_cnt != pushed_cnt) begin
      tests_failed++;
      $display("[TB] FAIL rand_lost: delivered=%0d expected %0d", popped_cnt, pushed_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_stall();
    test_single_requester();
    test_reset_mid_packet();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
